// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the memory stage: FUNCT3 access encodings,
// the MEM FSM state type and byte-lane helper functions.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_e;

    // Undefined funct3 encodings fall through to word access.
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: byte_en = 4'b0001 << a;
            F3_H, F3_HU: byte_en = 4'b0011 << {a[1], 1'b0};
            default:     byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B, F3_BU: store_lanes = {4{d[7:0]}};
            F3_H, F3_HU: store_lanes = {2{d[15:0]}};
            default:     store_lanes = d;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: misaligned = 1'b0;
            F3_H, F3_HU: misaligned = a[0];
            default:     misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data_out = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data_out = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data_out = {24'd0, byte_sel};
            F3_HU:   data_out = {16'd0, half_sel};
            default: data_out = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM register, req/ack data-memory access with timeout,
// load extension and front-end stall. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALU_OUT_EX,
    input  logic [31:0] STORE_DATA_EX,
    input  logic [2:0]  FUNCT3_EX,
    input  logic [4:0]  RD_EX,
    input  logic        RegWrite_EX,
    input  logic        MemtoReg_EX,
    input  logic        MemRead_EX,
    input  logic        MemWrite_EX,
    output logic        STALL,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [31:0] DMEM_WDATA,
    output logic [3:0]  DMEM_BE,
    input  logic        DMEM_ACK,
    input  logic [31:0] DMEM_RDATA,
    output logic [31:0] ALU_OUT_MEM,
    output logic [31:0] MEM_DATA_MEM,
    output logic [4:0]  RD_MEM,
    output logic        RegWrite_MEM,
    output logic        MemtoReg_MEM,
    output logic        BUS_ERR_MEM
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             req_q, req_d, we_q, we_d;
    logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [2:0]       f3_q, f3_d;
    logic             is_load_q, is_load_d;
    logic             pend_rw_q, pend_rw_d, pend_m2r_q, pend_m2r_d;
    logic [31:0]      alu_out_q, alu_out_d, mem_data_q, mem_data_d;
    logic [4:0]       rd_q, rd_d;
    logic             regwrite_q, regwrite_d, memtoreg_q, memtoreg_d;
    logic             bus_err_q, bus_err_d, trap_q, trap_d;
    logic             mem_op, mis_trap;
    logic [31:0]      ext_data;

    load_extend u_load_extend (
        .rdata    (DMEM_RDATA),
        .addr_lo  (alu_out_q[1:0]),
        .funct3   (f3_q),
        .data_out (ext_data)
    );

    assign mem_op  = MemRead_EX | MemWrite_EX;
    assign cnt_inc = cnt_q + 1'b1;

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_trap = mem_op & misaligned(FUNCT3_EX, ALU_OUT_EX[1:0]);
`else
    assign mis_trap = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        f3_d       = f3_q;
        is_load_d  = is_load_q;
        pend_rw_d  = pend_rw_q;
        pend_m2r_d = pend_m2r_q;
        alu_out_d  = alu_out_q;
        mem_data_d = mem_data_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        bus_err_d  = 1'b0;
        trap_d     = 1'b0;
        STALL      = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                alu_out_d  = ALU_OUT_EX;
                rd_d       = RD_EX;
                regwrite_d = RegWrite_EX;
                memtoreg_d = MemtoReg_EX;
                cnt_d      = '0;
                if (trap_q) begin
                    // The trapped op is still held in EX for this cycle; retire it as a bubble.
                    regwrite_d = 1'b0;
                    memtoreg_d = 1'b0;
                end else if (mis_trap) begin
                    STALL      = 1'b1;
                    bus_err_d  = 1'b1;
                    trap_d     = 1'b1;
                    regwrite_d = 1'b0;
                    memtoreg_d = 1'b0;
                end else if (mem_op) begin
                    STALL      = 1'b1;
                    regwrite_d = 1'b0;
                    memtoreg_d = 1'b0;
                    pend_rw_d  = RegWrite_EX;
                    pend_m2r_d = MemtoReg_EX;
                    req_d      = 1'b1;
                    we_d       = MemWrite_EX;
                    is_load_d  = MemRead_EX;
                    addr_d     = {ALU_OUT_EX[31:2], 2'b00};
                    be_d       = byte_en(FUNCT3_EX, ALU_OUT_EX[1:0]);
                    wdata_d    = store_lanes(FUNCT3_EX, STORE_DATA_EX);
                    f3_d       = FUNCT3_EX;
                    state_d    = MEM_BUSY;
                end
            end
            MEM_BUSY: begin
                STALL = 1'b1;
                if (DMEM_ACK) begin
                    STALL      = 1'b0;
                    req_d      = 1'b0;
                    cnt_d      = '0;
                    regwrite_d = pend_rw_q;
                    memtoreg_d = pend_m2r_q;
                    if (is_load_q) mem_data_d = ext_data;
                    state_d    = MEM_IDLE;
                end else if (cnt_inc == CNT_MAX) begin
                    // Abort releases the front end so the faulting op is not reissued.
                    STALL     = 1'b0;
                    req_d     = 1'b0;
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                    state_d   = MEM_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MEM_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            f3_q       <= '0;
            is_load_q  <= 1'b0;
            pend_rw_q  <= 1'b0;
            pend_m2r_q <= 1'b0;
            alu_out_q  <= '0;
            mem_data_q <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            bus_err_q  <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            f3_q       <= f3_d;
            is_load_q  <= is_load_d;
            pend_rw_q  <= pend_rw_d;
            pend_m2r_q <= pend_m2r_d;
            alu_out_q  <= alu_out_d;
            mem_data_q <= mem_data_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            bus_err_q  <= bus_err_d;
            trap_q     <= trap_d;
        end
    end

    assign DMEM_REQ     = req_q;
    assign DMEM_WE      = we_q;
    assign DMEM_ADDR    = addr_q;
    assign DMEM_WDATA   = wdata_q;
    assign DMEM_BE      = be_q;
    assign ALU_OUT_MEM  = alu_out_q;
    assign MEM_DATA_MEM = mem_data_q;
    assign RD_MEM       = rd_q;
    assign RegWrite_MEM = regwrite_q;
    assign MemtoReg_MEM = memtoreg_q;
    assign BUS_ERR_MEM  = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, timeout, pass-through, async reset.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] ALU_OUT_EX, STORE_DATA_EX;
    logic [2:0]  FUNCT3_EX;
    logic [4:0]  RD_EX;
    logic        RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX;
    logic        STALL, DMEM_REQ, DMEM_WE, DMEM_ACK;
    logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
    logic [3:0]  DMEM_BE;
    logic [31:0] ALU_OUT_MEM, MEM_DATA_MEM;
    logic [4:0]  RD_MEM;
    logic        RegWrite_MEM, MemtoReg_MEM, BUS_ERR_MEM;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_stage #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ALU_OUT_EX(ALU_OUT_EX), .STORE_DATA_EX(STORE_DATA_EX), .FUNCT3_EX(FUNCT3_EX),
        .RD_EX(RD_EX), .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX),
        .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
        .STALL(STALL), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE), .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
        .ALU_OUT_MEM(ALU_OUT_MEM), .MEM_DATA_MEM(MEM_DATA_MEM), .RD_MEM(RD_MEM),
        .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM), .BUS_ERR_MEM(BUS_ERR_MEM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_ex(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] f3,
                          input logic [4:0] rd, input logic rw, input logic m2r,
                          input logic mr, input logic mw);
        ALU_OUT_EX = a; STORE_DATA_EX = sd; FUNCT3_EX = f3; RD_EX = rd;
        RegWrite_EX = rw; MemtoReg_EX = m2r; MemRead_EX = mr; MemWrite_EX = mw;
    endtask

    // One access with ack on the second BUSY cycle; returns the bus signals seen while requesting.
    task automatic run_access(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] f3,
                              input logic ld, input logic [31:0] rword,
                              output logic [3:0] be, output logic [31:0] wd,
                              output logic we, output logic [31:0] ad);
        set_ex(a, sd, f3, 5'd7, ld, ld, ld, ~ld);
        #1 chk("stall_issue", STALL, 1);
        chk("req_issue", DMEM_REQ, 0);
        @(negedge clk);
        chk("req_busy", DMEM_REQ, 1);
        chk("stall_busy", STALL, 1);
        chk("rw_busy", RegWrite_MEM, 0);
        be = DMEM_BE; wd = DMEM_WDATA; we = DMEM_WE; ad = DMEM_ADDR;
        @(negedge clk);
        DMEM_ACK = 1'b1; DMEM_RDATA = rword;
        #1 chk("stall_ack", STALL, 0);
        @(negedge clk);
        DMEM_ACK = 1'b0;
        set_ex(32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("req_done", DMEM_REQ, 0);
    endtask

    logic [3:0]  be;
    logic [31:0] wd, ad;
    logic        we;
    int          n;

    initial begin
        set_ex(32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        DMEM_ACK = 1'b0; DMEM_RDATA = 32'h0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req", DMEM_REQ, 0);
        chk("rst_alu", ALU_OUT_MEM, 0);
        chk("rst_rw", RegWrite_MEM, 0);
        chk("rst_err", BUS_ERR_MEM, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // LW full word
        run_access(32'h100, 32'h0, 3'b010, 1'b1, 32'hDEADBEEF, be, wd, we, ad);
        chk("lw_addr", ad, 32'h100);
        chk("lw_be", be, 4'b1111);
        chk("lw_we", we, 0);
        chk("lw_data", MEM_DATA_MEM, 32'hDEADBEEF);
        chk("lw_rw", RegWrite_MEM, 1);
        chk("lw_m2r", MemtoReg_MEM, 1);
        chk("lw_rd", RD_MEM, 7);
        @(negedge clk);
        chk("lw_rw_once", RegWrite_MEM, 0);

        // Sub-word loads
        run_access(32'h103, 32'h0, 3'b000, 1'b1, 32'h80123456, be, wd, we, ad);
        chk("lb_data", MEM_DATA_MEM, 32'hFFFFFF80);
        chk("lb_addr", ad, 32'h100);
        run_access(32'h103, 32'h0, 3'b100, 1'b1, 32'h80123456, be, wd, we, ad);
        chk("lbu_data", MEM_DATA_MEM, 32'h00000080);
        run_access(32'h102, 32'h0, 3'b101, 1'b1, 32'hBEEF1234, be, wd, we, ad);
        chk("lhu_data", MEM_DATA_MEM, 32'h0000BEEF);
        run_access(32'h102, 32'h0, 3'b001, 1'b1, 32'hBEEF1234, be, wd, we, ad);
        chk("lh_data", MEM_DATA_MEM, 32'hFFFFBEEF);
        run_access(32'h101, 32'h0, 3'b000, 1'b1, 32'h12347F56, be, wd, we, ad);
        chk("lb_pos_data", MEM_DATA_MEM, 32'h0000007F);

        // Stores
        run_access(32'h201, 32'h000000AB, 3'b000, 1'b0, 32'h0, be, wd, we, ad);
        chk("sb_be", be, 4'b0010);
        chk("sb_wdata", wd, 32'hABABABAB);
        chk("sb_we", we, 1);
        chk("sb_addr", ad, 32'h200);
        chk("sb_rw", RegWrite_MEM, 0);
        chk("sb_data_hold", MEM_DATA_MEM, 32'h0000007F);
        run_access(32'h202, 32'h00001234, 3'b001, 1'b0, 32'h0, be, wd, we, ad);
        chk("sh_be", be, 4'b1100);
        chk("sh_wdata", wd, 32'h12341234);
        run_access(32'h204, 32'hCAFEF00D, 3'b010, 1'b0, 32'h0, be, wd, we, ad);
        chk("sw_be", be, 4'b1111);
        chk("sw_wdata", wd, 32'hCAFEF00D);
        chk("sw_addr", ad, 32'h204);

        // Timeout: ack withheld
        set_ex(32'h300, 32'h0, 3'b010, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        n = 0;
        while (DMEM_REQ && n < 40) begin
            chk("to_err_low", BUS_ERR_MEM, 0);
            n++;
            @(negedge clk);
        end
        chk("to_cycles", n, 16);
        chk("to_err", BUS_ERR_MEM, 1);
        chk("to_rw", RegWrite_MEM, 0);
        set_ex(32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("to_err_pulse", BUS_ERR_MEM, 0);
        chk("to_idle_req", DMEM_REQ, 0);

        // ALU pass-through, back to back
        set_ex(32'h11, 32'h0, 3'b000, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("add_stall", STALL, 0);
        @(negedge clk);
        chk("add1_alu", ALU_OUT_MEM, 32'h11);
        chk("add1_rw", RegWrite_MEM, 1);
        chk("add1_rd", RD_MEM, 3);
        set_ex(32'h22, 32'h0, 3'b000, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        DMEM_ACK = 1'b1;
        @(negedge clk);
        chk("add2_alu", ALU_OUT_MEM, 32'h22);
        chk("add2_rw", RegWrite_MEM, 0);
        chk("add2_rd", RD_MEM, 4);
        chk("idle_ack_req", DMEM_REQ, 0);
        DMEM_ACK = 1'b0;

`ifdef MEM_MISALIGN_TRAP_EN
        set_ex(32'h102, 32'h0, 3'b010, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 chk("mis_stall", STALL, 1);
        @(negedge clk);
        chk("mis_req", DMEM_REQ, 0);
        chk("mis_err", BUS_ERR_MEM, 1);
        chk("mis_rw", RegWrite_MEM, 0);
        chk("mis_stall_rel", STALL, 0);
        set_ex(32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("mis_err_pulse", BUS_ERR_MEM, 0);
`endif

        // Reset while BUSY
        set_ex(32'h400, 32'h0, 3'b010, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("rb_req", DMEM_REQ, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_req_drop", DMEM_REQ, 0);
        chk("rb_alu", ALU_OUT_MEM, 0);
        chk("rb_rw", RegWrite_MEM, 0);
        set_ex(32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rb_after_req", DMEM_REQ, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
